axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI4 responder that serves the core's instruction-fetch and data-memory traffic from an on-chip word-addressed SRAM. It is the slave end of the AXI path: the core's fetch and load/store ports, once bridged to AXI, arrive here through the interconnect. Each read and write transaction is handled as a single-ID INCR burst. The block answers with OKAY or DECERR responses, depending on whether the address is in range.

## Interface
Parameters:
- ID_BITS, 4: width of ARID/AWID/RID/BID.
- ADDR_BITS, 32: address width.
- DATA_BITS, 32: data width; WSTRB width is DATA_BITS/8.
- DEPTH_WORDS, 16384: SRAM depth in DATA_BITS words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports (ARESETn: reset, asynchronous, active-low; ACLK: clock):
- ACLK  in  1  clock.
- ARESETn  in  1  async active-low reset.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_BITS/ADDR_BITS/4/3/2  read address.
- ARVALID in 1; ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_BITS/DATA_BITS/2/1  read data.
- RVALID out 1; RREADY in 1.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_BITS/ADDR_BITS/4/3/2  write address.
- AWVALID in 1; AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_BITS/DATA_BITS/8/1  write data.
- WVALID in 1; WREADY out 1.
- BID/BRESP  out  ID_BITS/2  write response.
- BVALID out 1; BREADY in 1.

## Operation
- FSM states:
  - IDLE
  - R_FETCH
  - R_DATA
  - W_DATA
  - W_RESP
- IDLE:
  - ARREADY and AWREADY are driven combinationally from the grant. At most one of them is high.
  - Only one valid: grant it.
  - Both valid: grant the channel not served last. After reset, read wins.
  - AR handshake: latch ID, address, and len into cnt; go to R_FETCH.
  - AW handshake: latch ID, address, and len into cnt; clear the err flags; go to W_DATA.
- Size and burst type:
  - ARSIZE/AWSIZE are treated as 2 (4 bytes per beat).
  - ARBURST/AWBURST are always treated as INCR.
  - Beat address = start address + 4*beat. No 4KB wrap.
- Range check, per beat: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS. Word index = (addr − BASE_ADDR) >> 2.
- R_FETCH:
  - SRAM read of the current beat; go to R_DATA.
- R_DATA:
  - Outputs:
    - RVALID = 1.
    - RRESP = 2'b00 for an in-range beat, 2'b11 for an out-of-range beat.
    - RDATA = 0 for an out-of-range beat.
    - RLAST = (cnt == 0).
  - R handshake on a non-last beat: issue the SRAM read of the next beat in the same cycle, decrement cnt, stay in R_DATA.
  - R handshake on the last beat: go to IDLE.
- W_DATA:
  - WREADY = 1.
  - Each W handshake writes the in-range beat with per-byte enables from WSTRB. An out-of-range beat is dropped and sets the decerr flag.
  - WLAST must equal (cnt == 0). Any mismatch sets the slverr flag.
  - The burst ends on the counter, not on WLAST: the handshake at cnt == 0 goes to W_RESP.
- W_RESP:
  - BVALID = 1; BID = latched AWID.
  - BRESP = 2'b11 if decerr, else 2'b10 if slverr, else 2'b00.
  - B handshake goes to IDLE.
- SRAM contents are never cleared by reset.

## Timing
- Reset values:
  - ARREADY = AWREADY = WREADY = RVALID = BVALID = RLAST = 0.
  - RID, RDATA, RRESP, BID, BRESP = 0.
  - FSM = IDLE; last-served = write, so read wins first.
- Reset asserted mid-burst: return to IDLE immediately; the in-flight burst is abandoned with no response.
- Read latency: AR handshake at cycle T gives SRAM access at T+1 and RVALID with beat 0 at T+2.
- Read throughput: with RREADY held high, beats follow one per cycle.
- RVALID high with RREADY low: RDATA/RRESP/RLAST/RID stay stable, and no SRAM read is issued.
- Write: AW handshake at T gives WREADY at T+1.
  - The SRAM is written in the W handshake cycle.
  - The BVALID cycle follows the last W handshake.
  - Write throughput: one beat per cycle.
- Read-after-write to the same address returns the new data (the write completes before IDLE).
- Back-to-back transactions cost one IDLE cycle between them.

## Test plan
- Single read: preload word 5 = 32'hDEAD_BEEF; send ARADDR=0x14, ARLEN=0, RREADY=1 -> RVALID at T+2 with RDATA=32'hDEAD_BEEF, RRESP=00, RLAST=1, and RID echoing ARID.
- Burst read with backpressure: ARLEN=3 at 0x100; RREADY toggles 1,0,1,1,0,1 -> four beats with words 0x40..0x43 in order, RDATA held while stalled, RLAST only on beat 3.
- Strobed write then read: AWADDR=0x20, WDATA=32'h1122_3344, WSTRB=4'b0101 over a prior 0xFFFF_FFFF -> BRESP=00; read of 0x20 returns 32'hFF22_FF44.
- Out of range: ARADDR=4*DEPTH_WORDS -> RRESP=11, RDATA=0. A 2-beat write straddling the top word -> first beat written, BRESP=11.
- WLAST mismatch: AWLEN=1 with WLAST=1 on beat 0 -> both beats written, BRESP=10.
- Arbitration and reset: ARVALID and AWVALID both held high -> grants alternate R,W,R,W. ARESETn pulsed during R_DATA -> RVALID=0 the same cycle and FSM in IDLE; SRAM data is preserved.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-ID AXI4 responder in front of a word-addressed SRAM.
// One transaction at a time. Bursts are INCR with 4-byte beats. Any beat outside
// the SRAM window is answered with DECERR.
module axi_sram_slave #(
   parameter int                   ID_BITS     = 4,
   parameter int                   ADDR_BITS   = 32,
   parameter int                   DATA_BITS   = 32,
   parameter int                   DEPTH_WORDS = 16384,
   parameter logic [ADDR_BITS-1:0] BASE_ADDR   = '0
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   // read address
   input  logic [ID_BITS-1:0]     i_ARID,
   input  logic [ADDR_BITS-1:0]   i_ARADDR,
   input  logic [3:0]             i_ARLEN,
   input  logic [2:0]             i_ARSIZE,
   input  logic [1:0]             i_ARBURST,
   input  logic                   i_ARVALID,
   output logic                   o_ARREADY,
   // read data
   output logic [ID_BITS-1:0]     o_RID,
   output logic [DATA_BITS-1:0]   o_RDATA,
   output logic [1:0]             o_RRESP,
   output logic                   o_RLAST,
   output logic                   o_RVALID,
   input  logic                   i_RREADY,
   // write address
   input  logic [ID_BITS-1:0]     i_AWID,
   input  logic [ADDR_BITS-1:0]   i_AWADDR,
   input  logic [3:0]             i_AWLEN,
   input  logic [2:0]             i_AWSIZE,
   input  logic [1:0]             i_AWBURST,
   input  logic                   i_AWVALID,
   output logic                   o_AWREADY,
   // write data
   input  logic [DATA_BITS-1:0]   i_WDATA,
   input  logic [DATA_BITS/8-1:0] i_WSTRB,
   input  logic                   i_WLAST,
   input  logic                   i_WVALID,
   output logic                   o_WREADY,
   // write response
   output logic [ID_BITS-1:0]     o_BID,
   output logic [1:0]             o_BRESP,
   output logic                   o_BVALID,
   input  logic                   i_BREADY
);

   localparam int STRB_BITS = DATA_BITS / 8;
   localparam int IDX_BITS  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // Size of the SRAM window in bytes. It is one bit wider so that a window reaching
   // the top of the address space still compares correctly.
   localparam logic [ADDR_BITS:0] SPAN = (ADDR_BITS+1)'(DEPTH_WORDS) << 2;

   typedef enum logic [2:0] {S_IDLE, S_R_FETCH, S_R_DATA, S_W_DATA, S_W_RESP} state_t;

   state_t                 r_state;
   logic [ID_BITS-1:0]     r_id;
   logic [ADDR_BITS-1:0]   r_addr;      // address of the current beat
   logic [3:0]             r_cnt;       // beats remaining after the current one
   logic                   r_last_wr;   // last served channel was write
   logic                   r_decerr;
   logic                   r_slverr;
   logic                   r_rlast;
   logic [1:0]             r_rresp;
   logic [1:0]             r_bresp;
   logic [DATA_BITS-1:0]   r_mem [DEPTH_WORDS];
   logic [DATA_BITS-1:0]   r_sram_q;

   logic                   w_grant_r, w_grant_w;
   logic                   w_r_hs, w_r_next, w_w_hs;
   logic [ADDR_BITS-1:0]   w_rd_addr;
   logic                   w_rd_inr, w_wr_inr;
   logic                   w_sram_re, w_sram_we;
   logic [IDX_BITS-1:0]    w_rd_idx, w_wr_idx;
   logic                   w_decerr_n, w_slverr_n;

   // Size and burst type are fixed at 4-byte INCR, so these fields carry no information.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, i_ARSIZE, i_ARBURST, i_AWSIZE, i_AWBURST};

   function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
      logic [ADDR_BITS-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
   endfunction

   function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
      return IDX_BITS'((a - BASE_ADDR) >> 2);
   endfunction

   // When both channels are valid, the one not served last wins.
   assign w_grant_r = (r_state == S_IDLE) && i_ARVALID && (!i_AWVALID || r_last_wr);
   assign w_grant_w = (r_state == S_IDLE) && i_AWVALID && !w_grant_r;
   assign o_ARREADY = w_grant_r;
   assign o_AWREADY = w_grant_w;

   assign w_r_hs     = (r_state == S_R_DATA) && i_RREADY;
   assign w_r_next   = w_r_hs && !r_rlast;
   // In R_DATA the SRAM is fetched one beat ahead so that beats can issue back to back.
   assign w_rd_addr  = (r_state == S_R_DATA) ? r_addr + ADDR_BITS'(4) : r_addr;
   assign w_rd_inr   = in_range(w_rd_addr);
   assign w_rd_idx   = word_idx(w_rd_addr);
   assign w_sram_re  = ((r_state == S_R_FETCH) || w_r_next) && w_rd_inr;

   assign w_w_hs     = (r_state == S_W_DATA) && i_WVALID;
   assign w_wr_inr   = in_range(r_addr);
   assign w_wr_idx   = word_idx(r_addr);
   assign w_sram_we  = w_w_hs && w_wr_inr;
   assign w_decerr_n = r_decerr | !w_wr_inr;
   assign w_slverr_n = r_slverr | (i_WLAST != (r_cnt == 4'd0));

   assign o_RVALID = (r_state == S_R_DATA);
   assign o_RID    = r_id;
   assign o_RRESP  = r_rresp;
   assign o_RLAST  = r_rlast;
   assign o_RDATA  = (o_RVALID && (r_rresp == 2'b00)) ? r_sram_q : '0;
   assign o_WREADY = (r_state == S_W_DATA);
   assign o_BVALID = (r_state == S_W_RESP);
   assign o_BID    = r_id;
   assign o_BRESP  = r_bresp;

   // SRAM read port. There is no reset, and the last fetched word is held while R is stalled.
   always_ff @(posedge ACLK) begin
      if (w_sram_re) r_sram_q <= r_mem[w_rd_idx];
   end

   // SRAM write port with byte enables. The contents survive reset.
   always_ff @(posedge ACLK) begin
      if (w_sram_we) begin
         for (int b = 0; b < STRB_BITS; b++)
            if (i_WSTRB[b]) r_mem[w_wr_idx][8*b +: 8] <= i_WDATA[8*b +: 8];
      end
   end

   // Transaction FSM: arbitration, burst counting and the response registers.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state   <= S_IDLE;
         r_id      <= '0;
         r_addr    <= '0;
         r_cnt     <= '0;
         r_last_wr <= 1'b1;
         r_decerr  <= 1'b0;
         r_slverr  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= 2'b00;
         r_bresp   <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_r) begin
                  r_id      <= i_ARID;
                  r_addr    <= i_ARADDR;
                  r_cnt     <= i_ARLEN;
                  r_last_wr <= 1'b0;
                  r_state   <= S_R_FETCH;
               end else if (w_grant_w) begin
                  r_id      <= i_AWID;
                  r_addr    <= i_AWADDR;
                  r_cnt     <= i_AWLEN;
                  r_last_wr <= 1'b1;
                  r_decerr  <= 1'b0;
                  r_slverr  <= 1'b0;
                  r_state   <= S_W_DATA;
               end
            end
            S_R_FETCH: begin
               r_rresp <= w_rd_inr ? 2'b00 : 2'b11;
               r_rlast <= (r_cnt == 4'd0);
               r_state <= S_R_DATA;
            end
            S_R_DATA: begin
               if (w_r_hs) begin
                  if (r_rlast) begin
                     r_rlast <= 1'b0;
                     r_rresp <= 2'b00;
                     r_state <= S_IDLE;
                  end else begin
                     r_addr  <= w_rd_addr;
                     r_cnt   <= r_cnt - 4'd1;
                     r_rresp <= w_rd_inr ? 2'b00 : 2'b11;
                     r_rlast <= (r_cnt == 4'd1);
                  end
               end
            end
            S_W_DATA: begin
               if (w_w_hs) begin
                  r_addr   <= r_addr + ADDR_BITS'(4);
                  r_cnt    <= r_cnt - 4'd1;
                  r_decerr <= w_decerr_n;
                  r_slverr <= w_slverr_n;
                  // The burst length comes from the counter. WLAST only affects the response.
                  if (r_cnt == 4'd0) begin
                     r_bresp <= w_decerr_n ? 2'b11 : (w_slverr_n ? 2'b10 : 2'b00);
                     r_state <= S_W_RESP;
                  end
               end
            end
            S_W_RESP: begin
               if (i_BREADY) begin
                  r_bresp <= 2'b00;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed testbench for axi_sram_slave. A byte-level memory model generates the
// expected R beats and B responses. These go into scoreboard queues and are popped
// as the DUT answers.
module tb_axi_sram_slave;
   localparam int DEPTH = 16384;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic [3:0]  i_ARID, i_AWID, o_RID, o_BID;
   logic [31:0] i_ARADDR, i_AWADDR, o_RDATA, i_WDATA;
   logic [3:0]  i_ARLEN, i_AWLEN, i_WSTRB;
   logic [2:0]  i_ARSIZE, i_AWSIZE;
   logic [1:0]  i_ARBURST, i_AWBURST, o_RRESP, o_BRESP;
   logic        i_ARVALID, o_ARREADY, o_RLAST, o_RVALID, i_RREADY;
   logic        i_AWVALID, o_AWREADY, i_WLAST, i_WVALID, o_WREADY;
   logic        o_BVALID, i_BREADY;

   always #5 ACLK = ~ACLK;

   axi_sram_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .i_ARID(i_ARID), .i_ARADDR(i_ARADDR), .i_ARLEN(i_ARLEN), .i_ARSIZE(i_ARSIZE),
      .i_ARBURST(i_ARBURST), .i_ARVALID(i_ARVALID), .o_ARREADY(o_ARREADY),
      .o_RID(o_RID), .o_RDATA(o_RDATA), .o_RRESP(o_RRESP), .o_RLAST(o_RLAST),
      .o_RVALID(o_RVALID), .i_RREADY(i_RREADY),
      .i_AWID(i_AWID), .i_AWADDR(i_AWADDR), .i_AWLEN(i_AWLEN), .i_AWSIZE(i_AWSIZE),
      .i_AWBURST(i_AWBURST), .i_AWVALID(i_AWVALID), .o_AWREADY(o_AWREADY),
      .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST), .i_WVALID(i_WVALID),
      .o_WREADY(o_WREADY),
      .o_BID(o_BID), .o_BRESP(o_BRESP), .o_BVALID(o_BVALID), .i_BREADY(i_BREADY)
   );

   typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
   typedef struct packed {logic [1:0] resp; logic [3:0] id;} bexp_t;
   rbeat_t rq[$];
   bexp_t  bq[$];

   logic [31:0] model [DEPTH];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic        wl [16];
   logic        rpat [8];
   int          rpat_n;
   int          checks = 0;
   int          errors = 0;

   function automatic bit inr(input logic [31:0] a);
      return a < 32'(4*DEPTH);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sel(input int k);
      case (k)
         0: return o_ARREADY;
         1: return o_AWREADY;
         2: return o_WREADY;
         default: return o_RVALID;
      endcase
   endfunction

   // Entered at a negedge. Returns at negedge+1 with the selected signal high,
   // or after the cycle budget runs out. An expired budget counts as a failure.
   task automatic wait_sig(input int k, input string tag);
      int n;
      n = 0;
      #1;
      while (sel(k) !== 1'b1 && n < 64) begin
         @(negedge ACLK); #1; n++;
      end
      chk({tag, "_timeout"}, 64'(n < 64), 64'd1);
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len);
      bexp_t e;
      bit dec, slv;
      logic [31:0] a;
      dec = 0; slv = 0;
      for (int b = 0; b <= len; b++) begin
         a = addr + 32'(4*b);
         if (inr(a)) begin
            for (int k = 0; k < 4; k++)
               if (ws[b][k]) model[a >> 2][8*k +: 8] = wd[b][8*k +: 8];
         end else dec = 1;
         if (wl[b] != (b == len)) slv = 1;
      end
      e.id = id;
      e.resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
      bq.push_back(e);
      @(negedge ACLK);
      i_AWID = id; i_AWADDR = addr; i_AWLEN = 4'(len); i_AWSIZE = 3'd2; i_AWBURST = 2'b01;
      i_AWVALID = 1'b1;
      wait_sig(1, "aw");
      @(negedge ACLK);
      i_AWVALID = 1'b0;
      #1 chk("w_ready_latency", 64'(o_WREADY), 64'd1);
      for (int b = 0; b <= len; b++) begin
         i_WDATA = wd[b]; i_WSTRB = ws[b]; i_WLAST = wl[b]; i_WVALID = 1'b1;
         wait_sig(2, "w");
         @(negedge ACLK);
      end
      i_WVALID = 1'b0; i_WLAST = 1'b0; i_BREADY = 1'b1;
      #1;
      e = bq.pop_front();
      chk("b_valid", 64'(o_BVALID), 64'd1);
      chk("b_resp", 64'(o_BRESP), 64'(e.resp));
      chk("b_id", 64'(o_BID), 64'(e.id));
      @(negedge ACLK);
      i_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len);
      rbeat_t e;
      logic [31:0] a;
      int cyc, i;
      for (int b = 0; b <= len; b++) begin
         a = addr + 32'(4*b);
         e.data = inr(a) ? model[a >> 2] : 32'h0;
         e.resp = inr(a) ? 2'b00 : 2'b11;
         e.last = (b == len);
         e.id = id;
         rq.push_back(e);
      end
      @(negedge ACLK);
      i_ARID = id; i_ARADDR = addr; i_ARLEN = 4'(len); i_ARSIZE = 3'd2; i_ARBURST = 2'b01;
      i_ARVALID = 1'b1;
      wait_sig(0, "ar");
      @(negedge ACLK);
      i_ARVALID = 1'b0;
      #1 chk("r_latency_t1", 64'(o_RVALID), 64'd0);
      @(negedge ACLK);
      #1 chk("r_latency_t2", 64'(o_RVALID), 64'd1);
      cyc = 0; i = 0;
      while (rq.size() > 0 && cyc < 64) begin
         i_RREADY = rpat[i % rpat_n];
         i++;
         #1;
         chk("r_valid", 64'(o_RVALID), 64'd1);
         if (o_RVALID) begin
            e = rq[0];
            chk("r_data", 64'(o_RDATA), 64'(e.data));
            chk("r_resp", 64'(o_RRESP), 64'(e.resp));
            chk("r_last", 64'(o_RLAST), 64'(e.last));
            chk("r_id", 64'(o_RID), 64'(e.id));
            if (i_RREADY) void'(rq.pop_front());
         end
         @(negedge ACLK); #1;
         cyc++;
      end
      chk("r_drain", 64'(rq.size()), 64'd0);
      rq.delete();
      i_RREADY = 1'b0;
      chk("r_done_idle", 64'(o_RVALID), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit gr [4];
      int ng, n;
      ARESETn = 1'b0;
      i_ARID = '0; i_ARADDR = '0; i_ARLEN = '0; i_ARSIZE = '0; i_ARBURST = '0; i_ARVALID = 1'b0;
      i_AWID = '0; i_AWADDR = '0; i_AWLEN = '0; i_AWSIZE = '0; i_AWBURST = '0; i_AWVALID = 1'b0;
      i_WDATA = '0; i_WSTRB = '0; i_WLAST = 1'b0; i_WVALID = 1'b0;
      i_RREADY = 1'b0; i_BREADY = 1'b0;
      for (int k = 0; k < 8; k++) rpat[k] = 1'b1;
      rpat_n = 1;
      repeat (3) @(negedge ACLK);
      #1;
      chk("rst_arready", 64'(o_ARREADY), 64'd0);
      chk("rst_awready", 64'(o_AWREADY), 64'd0);
      chk("rst_wready", 64'(o_WREADY), 64'd0);
      chk("rst_rvalid", 64'(o_RVALID), 64'd0);
      chk("rst_bvalid", 64'(o_BVALID), 64'd0);
      chk("rst_rlast", 64'(o_RLAST), 64'd0);
      chk("rst_rfields", {o_RID, o_RDATA, o_RRESP}, 64'd0);
      chk("rst_bfields", {o_BID, o_BRESP}, 64'd0);
      @(negedge ACLK);
      ARESETn = 1'b1;

      // Preload word 5 and read it back as a single beat.
      wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF; wl[0] = 1'b1;
      axi_write(4'd3, 32'h14, 0);
      axi_read(4'd5, 32'h14, 0);

      // Four-beat burst at 0x100, then read it back with RREADY backpressure.
      for (int b = 0; b < 4; b++) begin
         wd[b] = 32'hA000_0040 + 32'(b); ws[b] = 4'hF; wl[b] = (b == 3);
      end
      axi_write(4'd9, 32'h100, 3);
      rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b1; rpat[3] = 1'b1; rpat[4] = 1'b0; rpat[5] = 1'b1;
      rpat_n = 6;
      axi_read(4'd6, 32'h100, 3);
      rpat_n = 1;

      // Partial-strobe write over a word that is all ones.
      wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF; wl[0] = 1'b1;
      axi_write(4'd1, 32'h20, 0);
      wd[0] = 32'h1122_3344; ws[0] = 4'b0101; wl[0] = 1'b1;
      axi_write(4'd2, 32'h20, 0);
      axi_read(4'd2, 32'h20, 0);
      chk("strobe_model", 64'(model[8]), 64'hFF22_FF44);

      // Out-of-range read, then a write burst that runs past the top word.
      axi_read(4'd4, 32'(4*DEPTH), 0);
      wd[0] = 32'h5555_AAAA; ws[0] = 4'hF; wl[0] = 1'b0;
      wd[1] = 32'h1234_5678; ws[1] = 4'hF; wl[1] = 1'b1;
      axi_write(4'd7, 32'(4*DEPTH - 4), 1);
      axi_read(4'd7, 32'(4*DEPTH - 4), 1);

      // WLAST asserted early: both beats are still written and the response is SLVERR.
      wd[0] = 32'hCAFE_0001; ws[0] = 4'hF; wl[0] = 1'b1;
      wd[1] = 32'hCAFE_0002; ws[1] = 4'hF; wl[1] = 1'b1;
      axi_write(4'd8, 32'h30, 1);
      axi_read(4'd8, 32'h30, 1);

      // Arbitration. The last grant before this point was a write, so read goes first.
      wd[0] = 32'h0000_600D; ws[0] = 4'hF; wl[0] = 1'b1;
      axi_write(4'd2, 32'h200, 0);
      @(negedge ACLK);
      i_ARID = 4'd1; i_ARADDR = 32'h14; i_ARLEN = 4'd0; i_ARVALID = 1'b1;
      i_AWID = 4'd2; i_AWADDR = 32'h200; i_AWLEN = 4'd0; i_AWVALID = 1'b1;
      i_WDATA = 32'h0000_600D; i_WSTRB = 4'hF; i_WLAST = 1'b1; i_WVALID = 1'b1;
      i_RREADY = 1'b1; i_BREADY = 1'b1;
      ng = 0; n = 0;
      while (ng < 4 && n < 100) begin
         #1;
         chk("arb_onehot", 64'(o_ARREADY & o_AWREADY), 64'd0);
         if (o_ARREADY || o_AWREADY) begin
            gr[ng] = o_ARREADY;
            ng++;
         end
         @(negedge ACLK);
         n++;
      end
      i_ARVALID = 1'b0; i_AWVALID = 1'b0;
      repeat (6) @(negedge ACLK);
      i_WVALID = 1'b0; i_WLAST = 1'b0; i_RREADY = 1'b0; i_BREADY = 1'b0;
      chk("arb_count", 64'(ng), 64'd4);
      chk("arb_g0_read", 64'(gr[0]), 64'd1);
      chk("arb_g1_write", 64'(gr[1]), 64'd0);
      chk("arb_g2_read", 64'(gr[2]), 64'd1);
      chk("arb_g3_write", 64'(gr[3]), 64'd0);

      // Reset while R_DATA is stalled. The burst is dropped and the SRAM contents are kept.
      @(negedge ACLK);
      i_ARID = 4'd7; i_ARADDR = 32'h100; i_ARLEN = 4'd3; i_ARVALID = 1'b1;
      wait_sig(0, "ar_rst");
      @(negedge ACLK);
      i_ARVALID = 1'b0;
      @(negedge ACLK);
      #1 chk("rst_mid_rvalid_pre", 64'(o_RVALID), 64'd1);
      ARESETn = 1'b0;
      #1;
      chk("rst_mid_rvalid", 64'(o_RVALID), 64'd0);
      chk("rst_mid_rlast", 64'(o_RLAST), 64'd0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      axi_read(4'd3, 32'h100, 3);
      axi_read(4'd1, 32'h14, 0);
      axi_read(4'd2, 32'h200, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
